stream_mux_tx: RTL

- Parametrised successor to the fixed 5-input arbiter plus 32-to-8 FIFO path that feeds the TCP Tx byte stream.
- Merges CHANNELS first-word-fall-through (FWFT) 32-bit sources (FE-I4 receivers, TDC, …) with a masked round-robin arbiter.
- Buffers merged words in an internal FIFO of DEPTH words, then serialises each word to bytes under TCP almost-full backpressure.
- Sits between the per-channel receiver FIFOs and USR_TX_WE/USR_TX_WD in the top level.

---
 rtl/stream_mux_tx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/stream_mux_tx.sv
// stream_mux_tx: masked round-robin merge of FWFT word sources into a
// word FIFO, followed by an LSB-first word-to-byte packer with
// almost-full backpressure toward the TCP Tx byte stream.
// Optional build macro STREAM_MUX_CH_TAG_EN: when defined, the top nibble
// of every stored word is overwritten with (granted channel index + 1).
module stream_mux_tx #(
  parameter int CHANNELS  = 5,
  parameter int DEPTH     = 4096,
  parameter int CNT_WIDTH = 32
) (
  input  logic                      BUS_CLK,
  input  logic                      BUS_RST,
  input  logic [CHANNELS-1:0]       CH_ENABLE,
  input  logic [CHANNELS-1:0]       CH_EMPTY,
  input  logic [32*CHANNELS-1:0]    CH_DATA,
  output logic [CHANNELS-1:0]       CH_READ,
  input  logic                      TX_AFULL,
  output logic                      TX_WE,
  output logic [7:0]                TX_WD,
  output logic                      FIFO_EMPTY,
  output logic                      FIFO_FULL,
  output logic [$clog2(DEPTH):0]    FIFO_COUNT,
  output logic [CNT_WIDTH-1:0]      WORD_COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] req;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       grant_idx;
  logic [PW-1:0]       cand;
  logic                grant;
  logic [31:0]         grant_data;
  logic [31:0]         wr_data;

  logic [31:0]         mem [DEPTH];
  logic [AW-1:0]       wr_addr;
  logic [AW-1:0]       rd_addr;
  logic [AW:0]         count;
  logic                fifo_rd;

  logic [31:0]         pk_word;
  logic [1:0]          pk_idx;
  logic                pk_valid;
  logic                last_byte;

  assign req = ~CH_EMPTY & CH_ENABLE;

  // Pick the first requester after the last winner; no grant while the FIFO is full or in reset
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = rr_ptr;
    CH_READ   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = (cand == PW'(CHANNELS - 1)) ? '0 : cand + 1'b1;
      if (!grant && req[cand]) begin
        grant     = 1'b1;
        grant_idx = cand;
      end
    end
    if (BUS_RST || count[AW]) begin
      grant = 1'b0;
    end
    if (grant) begin
      CH_READ[grant_idx] = 1'b1;
    end
  end

  // Select the winner's data word from the flattened source bus
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_idx == PW'(k)) begin
        grant_data = CH_DATA[32*k +: 32];
      end
    end
  end

`ifdef STREAM_MUX_CH_TAG_EN
  assign wr_data = {4'(grant_idx) + 4'd1, grant_data[27:0]};
`else
  assign wr_data = grant_data;
`endif

  // Round-robin pointer remembers the last winner so the search starts just after it
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      rr_ptr <= PW'(CHANNELS - 1);
    end else if (grant) begin
      rr_ptr <= grant_idx;
    end
  end

  // Word storage; contents need no reset because the pointers define validity
  always_ff @(posedge BUS_CLK) begin
    if (grant) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      wr_addr <= '0;
      rd_addr <= '0;
      count   <= '0;
    end else begin
      if (grant) begin
        wr_addr <= wr_addr + 1'b1;
      end
      if (fifo_rd) begin
        rd_addr <= rd_addr + 1'b1;
      end
      case ({grant, fifo_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign FIFO_COUNT = count;
  assign FIFO_EMPTY = (count == '0);
  assign FIFO_FULL  = count[AW];

  assign TX_WE     = pk_valid & ~TX_AFULL;
  assign last_byte = TX_WE & (pk_idx == 2'd3);
  assign fifo_rd   = (count != '0) & (~pk_valid | last_byte);

  // Packer: reload on idle or on the final byte so consecutive words stream without a gap
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      pk_word    <= '0;
      pk_idx     <= '0;
      pk_valid   <= 1'b0;
      WORD_COUNT <= '0;
    end else begin
      if (fifo_rd) begin
        pk_word  <= mem[rd_addr];
        pk_idx   <= '0;
        pk_valid <= 1'b1;
      end else if (last_byte) begin
        pk_idx   <= '0;
        pk_valid <= 1'b0;
      end else if (TX_WE) begin
        pk_idx <= pk_idx + 1'b1;
      end
      if (last_byte) begin
        WORD_COUNT <= WORD_COUNT + 1'b1;
      end
    end
  end

  // Byte lane select, least significant byte first
  always_comb begin
    TX_WD = pk_word[7:0];
    case (pk_idx)
      2'd0: TX_WD = pk_word[7:0];
      2'd1: TX_WD = pk_word[15:8];
      2'd2: TX_WD = pk_word[23:16];
      2'd3: TX_WD = pk_word[31:24];
      default: TX_WD = pk_word[7:0];
    endcase
  end

endmodule
